// File: rtl/xoodyak_decrypt.sv
// xoodyak_decrypt: Xoodyak decryption stage.
// Takes the 384-bit Cyclist state after nonce/AD absorption, a 192-bit
// ciphertext block and a received 128-bit tag. It recovers the plaintext
// (Crypt phase), squeezes the tag (Squeeze phase) and compares the top
// TAG_W tag bits. One iterative Xoodoo core (one round per cycle) is
// shared by both phases.
//
// Ports:
//   eph1        clock, rising edge
//   reset       synchronous active-high reset
//   start       one-cycle request, sampled only in IDLE
//   state_in    post-AD state, captured with start
//   ciphertext  ciphertext block, captured with start
//   tag_in      received tag, captured with start
//   plaintext   recovered plaintext (registered)
//   tag_out     computed tag (registered)
//   tag_ok      compared tag bits match (registered)
//   busy        high from CRYPT through SQZ
//   decdone     one-cycle completion pulse
//
// Optional feature: define XOODYAK_DEC_RELEASE_GUARD_EN to withhold the
// plaintext until the tag has verified.
//
// State layout: lane i (i = 4*y + x) occupies bits [383-32*i -: 32], so
// plane 0 is state[383:256] and lane x=0 of each plane is its top word.
module xoodyak_decrypt #(
    parameter int TAG_W = 128
) (
    input  logic         eph1,
    input  logic         reset,
    input  logic         start,
    input  logic [383:0] state_in,
    input  logic [191:0] ciphertext,
    input  logic [127:0] tag_in,
    output logic [191:0] plaintext,
    output logic [127:0] tag_out,
    output logic         tag_ok,
    output logic         busy,
    output logic         decdone
);

    typedef enum logic [1:0] {IDLE, CRYPT, SQZ, DONE} state_t;

    localparam logic [383:0] DOM_CRYPT = 384'h80;
    localparam logic [383:0] DOM_SQZ   = 384'h40;
    localparam logic [127:0] TAG_MASK  = {128{1'b1}} << (128 - TAG_W);

    state_t       fsm;
    logic [383:0] st_reg;
    logic [191:0] ct_reg;
    logic [127:0] tag_reg;
`ifdef XOODYAK_DEC_RELEASE_GUARD_EN
    logic [191:0] pt_hold;
`endif

    logic         perm_start;
    logic         perm_run;
    logic [3:0]   rnd;
    logic         perm_done;
    logic [383:0] perm_state;
    logic [383:0] perm_in;
    logic [383:0] round_in;
    logic [383:0] round_out;
    logic [31:0]  round_rc;
    logic [191:0] recovered;
    logic [383:0] seed;
    logic         tag_match;

    function automatic logic [31:0] rol32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Rotate every lane of a plane by n bits.
    function automatic logic [127:0] rolp(input logic [127:0] p, input int n);
        return {rol32(p[127:96], n), rol32(p[95:64], n),
                rol32(p[63:32], n), rol32(p[31:0], n)};
    endfunction

    // Lane x receives lane x-1 (x=0 is the top word).
    function automatic logic [127:0] lane_shift1(input logic [127:0] p);
        return {p[31:0], p[127:32]};
    endfunction

    // Lane x receives lane x-2.
    function automatic logic [127:0] lane_shift2(input logic [127:0] p);
        return {p[63:0], p[127:64]};
    endfunction

    function automatic logic [31:0] round_const(input logic [3:0] i);
        case (i)
            4'd0:    return 32'h0000_0058;
            4'd1:    return 32'h0000_0038;
            4'd2:    return 32'h0000_03C0;
            4'd3:    return 32'h0000_00D0;
            4'd4:    return 32'h0000_0120;
            4'd5:    return 32'h0000_0014;
            4'd6:    return 32'h0000_0060;
            4'd7:    return 32'h0000_002C;
            4'd8:    return 32'h0000_0380;
            4'd9:    return 32'h0000_00F0;
            4'd10:   return 32'h0000_01A0;
            4'd11:   return 32'h0000_0012;
            default: return 32'h0;
        endcase
    endfunction

    // One Xoodoo round: theta, rho-west, iota, chi, rho-east.
    function automatic logic [383:0] xoodoo_round(input logic [383:0] s,
                                                  input logic [31:0]  rc);
        logic [127:0] a0, a1, a2, p, e, n0, n1, n2;
        a0 = s[383:256];
        a1 = s[255:128];
        a2 = s[127:0];
        p  = a0 ^ a1 ^ a2;
        e  = rolp(lane_shift1(p), 5) ^ rolp(lane_shift1(p), 14);
        a0 = a0 ^ e;
        a1 = lane_shift1(a1 ^ e);
        a2 = rolp(a2 ^ e, 11);
        a0[127:96] = a0[127:96] ^ rc;
        n0 = a0 ^ (~a1 & a2);
        n1 = a1 ^ (~a2 & a0);
        n2 = a2 ^ (~a0 & a1);
        return {n0, rolp(n1, 1), rolp(lane_shift2(n2), 8)};
    endfunction

    // The start cycle already applies round 0 to the fresh input, so
    // the 12th round lands at the end of start+11 and done is high at
    // start+12.
    always_comb begin
        perm_in   = st_reg ^ ((fsm == CRYPT) ? DOM_CRYPT : DOM_SQZ);
        round_in  = perm_start ? perm_in : perm_state;
        round_rc  = round_const(perm_start ? 4'd0 : rnd);
        round_out = xoodoo_round(round_in, round_rc);
        perm_done = perm_run && (rnd == 4'd12);
        recovered = ct_reg ^ perm_state[383:192];
        seed      = {ct_reg, perm_state[191:185], ~perm_state[184], perm_state[183:0]};
        // Full-width XOR then a single OR reduction: no early exit.
        tag_match = ~|((perm_state[127:0] ^ tag_reg) & TAG_MASK);
    end

    always_ff @(posedge eph1) begin
        if (reset) begin
            perm_run <= 1'b0;
            rnd      <= 4'd0;
        end else if (perm_start) begin
            perm_run <= 1'b1;
            rnd      <= 4'd1;
        end else if (perm_run) begin
            if (rnd == 4'd12)
                perm_run <= 1'b0;
            else
                rnd <= rnd + 4'd1;
        end
    end

    always_ff @(posedge eph1) begin
        if (perm_start || (perm_run && rnd != 4'd12))
            perm_state <= round_out;
    end

    // Operand registers; st_reg is reused for the squeeze seed.
    always_ff @(posedge eph1) begin
        if (fsm == IDLE && start) begin
            st_reg  <= state_in;
            ct_reg  <= ciphertext;
            tag_reg <= tag_in;
        end else if (fsm == CRYPT && perm_done) begin
            st_reg  <= seed;
`ifdef XOODYAK_DEC_RELEASE_GUARD_EN
            pt_hold <= recovered;
`endif
        end
    end

    always_ff @(posedge eph1) begin
        if (reset) begin
            fsm        <= IDLE;
            perm_start <= 1'b0;
            busy       <= 1'b0;
            decdone    <= 1'b0;
            plaintext  <= '0;
            tag_out    <= '0;
            tag_ok     <= 1'b0;
        end else begin
            perm_start <= 1'b0;
            decdone    <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        plaintext  <= '0;
                        tag_out    <= '0;
                        tag_ok     <= 1'b0;
                        perm_start <= 1'b1;
                        busy       <= 1'b1;
                        fsm        <= CRYPT;
                    end
                end
                CRYPT: begin
                    if (perm_done) begin
`ifndef XOODYAK_DEC_RELEASE_GUARD_EN
                        plaintext  <= recovered;
`endif
                        perm_start <= 1'b1;
                        fsm        <= SQZ;
                    end
                end
                SQZ: begin
                    if (perm_done) begin
                        tag_out <= perm_state[127:0];
                        tag_ok  <= tag_match;
`ifdef XOODYAK_DEC_RELEASE_GUARD_EN
                        plaintext <= tag_match ? pt_hold : '0;
`endif
                        busy    <= 1'b0;
                        decdone <= 1'b1;
                        fsm     <= DONE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xoodyak_decrypt.sv
// Directed bench for xoodyak_decrypt: a vector table built from a
// reference Xoodoo model (array-of-lanes form), applied back-to-back,
// plus hand sequences for busy rejection and reset corner cases.
// A second instance with TAG_W=64 runs on the same inputs.
module tb_xoodyak_decrypt;

    logic         eph1 = 1'b0;
    logic         reset;
    logic         start;
    logic [383:0] state_in;
    logic [191:0] ciphertext;
    logic [127:0] tag_in;
    logic [191:0] plaintext, plaintext64;
    logic [127:0] tag_out, tag_out64;
    logic         tag_ok, tag_ok64, busy, busy64, decdone, decdone64;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef XOODYAK_DEC_RELEASE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic [383:0] st;
        logic [191:0] pt;
        logic [191:0] ct_flip;
        logic [127:0] tag_flip;
        logic         ok;
        logic         ok64;
        logic [191:0] ct;
        logic [127:0] tag;
        logic [127:0] exp_tag;
    } vec_t;

    vec_t vecs[8];

    xoodyak_decrypt #(.TAG_W(128)) u_dut (
        .eph1(eph1), .reset(reset), .start(start), .state_in(state_in),
        .ciphertext(ciphertext), .tag_in(tag_in), .plaintext(plaintext),
        .tag_out(tag_out), .tag_ok(tag_ok), .busy(busy), .decdone(decdone)
    );

    xoodyak_decrypt #(.TAG_W(64)) u_dut64 (
        .eph1(eph1), .reset(reset), .start(start), .state_in(state_in),
        .ciphertext(ciphertext), .tag_in(tag_in), .plaintext(plaintext64),
        .tag_out(tag_out64), .tag_ok(tag_ok64), .busy(busy64), .decdone(decdone64)
    );

    always #5 eph1 = ~eph1;

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] rcon(input int r);
        case (r)
            0: return 32'h58;   1: return 32'h38;   2: return 32'h3C0;
            3: return 32'hD0;   4: return 32'h120;  5: return 32'h14;
            6: return 32'h60;   7: return 32'h2C;   8: return 32'h380;
            9: return 32'hF0;  10: return 32'h1A0; 11: return 32'h12;
            default: return 32'h0;
        endcase
    endfunction

    // Reference Xoodoo[12] on a 3x4 lane array; lane 4*y+x is the
    // (4*y+x)-th 32-bit word counted from the top of the vector.
    function automatic logic [383:0] xoodoo(input logic [383:0] s);
        logic [31:0]  a [3][4];
        logic [31:0]  b [3][4];
        logic [31:0]  p [4];
        logic [31:0]  t [4];
        logic [383:0] sh;
        logic [383:0] r;
        logic [1:0]   x, y, xm1, xm2, y1, y2;
        sh = s;
        for (int yi = 0; yi < 3; yi++)
            for (int xi = 0; xi < 4; xi++) begin
                y = 2'(yi); x = 2'(xi);
                a[y][x] = sh[383:352];
                sh = sh << 32;
            end
        for (int rd = 0; rd < 12; rd++) begin
            for (int xi = 0; xi < 4; xi++) begin
                x = 2'(xi);
                p[x] = a[2'd0][x] ^ a[2'd1][x] ^ a[2'd2][x];
            end
            for (int xi = 0; xi < 4; xi++) begin
                x = 2'(xi); xm1 = x - 2'd1;
                for (int yi = 0; yi < 3; yi++) begin
                    y = 2'(yi);
                    a[y][x] = a[y][x] ^ rl(p[xm1], 5) ^ rl(p[xm1], 14);
                end
            end
            for (int xi = 0; xi < 4; xi++) begin
                x = 2'(xi); t[x] = a[2'd1][x];
            end
            for (int xi = 0; xi < 4; xi++) begin
                x = 2'(xi); xm1 = x - 2'd1;
                a[2'd1][x] = t[xm1];
                a[2'd2][x] = rl(a[2'd2][x], 11);
            end
            a[2'd0][2'd0] = a[2'd0][2'd0] ^ rcon(rd);
            for (int yi = 0; yi < 3; yi++)
                for (int xi = 0; xi < 4; xi++) begin
                    y = 2'(yi); x = 2'(xi);
                    y1 = (y == 2'd2) ? 2'd0 : y + 2'd1;
                    y2 = (y == 2'd0) ? 2'd2 : y - 2'd1;
                    b[y][x] = ~a[y1][x] & a[y2][x];
                end
            for (int yi = 0; yi < 3; yi++)
                for (int xi = 0; xi < 4; xi++) begin
                    y = 2'(yi); x = 2'(xi);
                    a[y][x] = a[y][x] ^ b[y][x];
                end
            for (int xi = 0; xi < 4; xi++) begin
                x = 2'(xi); t[x] = a[2'd2][x];
            end
            for (int xi = 0; xi < 4; xi++) begin
                x = 2'(xi); xm2 = x - 2'd2;
                a[2'd1][x] = rl(a[2'd1][x], 1);
                a[2'd2][x] = rl(t[xm2], 8);
            end
        end
        r = '0;
        for (int yi = 0; yi < 3; yi++)
            for (int xi = 0; xi < 4; xi++) begin
                y = 2'(yi); x = 2'(xi);
                r = {r[351:0], a[y][x]};
            end
        return r;
    endfunction

    function automatic logic [127:0] squeeze(input logic [191:0] ct, input logic [383:0] perm1);
        logic [383:0] o;
        o = xoodoo({ct, perm1[191:0] ^ (192'h1 << 184)} ^ 384'h40);
        return o[127:0];
    endfunction

    task automatic prep(input int i);
        logic [383:0] perm1;
        logic [191:0] good_ct;
        perm1   = xoodoo(vecs[i].st ^ 384'h80);
        good_ct = vecs[i].pt ^ perm1[383:192];
        vecs[i].ct      = good_ct ^ vecs[i].ct_flip;
        vecs[i].tag     = squeeze(good_ct, perm1) ^ vecs[i].tag_flip;
        vecs[i].exp_tag = squeeze(vecs[i].ct, perm1);
    endtask

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    // Starts vector i in the current cycle (S) and returns in S+28.
    task automatic run_vec(input int i, input bit intrude);
        logic [191:0] exp_pt, pv_mid, pv_end;
        bit early;
        early  = 1'b0;
        exp_pt = vecs[i].pt ^ vecs[i].ct_flip;
        pv_mid = GUARD ? 192'h0 : exp_pt;
        pv_end = (GUARD && !vecs[i].ok) ? 192'h0 : exp_pt;
        state_in   = vecs[i].st;
        ciphertext = vecs[i].ct;
        tag_in     = vecs[i].tag;
        start      = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            tick();
            start = 1'b0;
            if (k == 1) begin
                state_in = ~state_in; ciphertext = ~ciphertext; tag_in = ~tag_in;
                chk($sformatf("v%0d_busy_s1", i), 384'(busy), 384'(1'b1));
                chk($sformatf("v%0d_tag_clr", i), 384'(tag_out), 384'(0));
                chk($sformatf("v%0d_pt_clr", i), 384'(plaintext), 384'(0));
            end
            if (k < 27 && (decdone || decdone64)) early = 1'b1;
            if (k == 14)
                chk($sformatf("v%0d_pt_s14", i), 384'(plaintext), 384'(pv_mid));
            if (k == 27) begin
                chk($sformatf("v%0d_early_done", i), 384'(early), 384'(1'b0));
                chk($sformatf("v%0d_decdone", i), 384'(decdone), 384'(1'b1));
                chk($sformatf("v%0d_busy_done", i), 384'(busy), 384'(1'b0));
                chk($sformatf("v%0d_pt", i), 384'(plaintext), 384'(pv_end));
                chk($sformatf("v%0d_tag", i), 384'(tag_out), 384'(vecs[i].exp_tag));
                chk($sformatf("v%0d_ok", i), 384'(tag_ok), 384'(vecs[i].ok));
                chk($sformatf("v%0d_ok64", i), 384'(tag_ok64), 384'(vecs[i].ok64));
                chk($sformatf("v%0d_tag64", i), 384'(tag_out64), 384'(vecs[i].exp_tag));
                chk($sformatf("v%0d_decdone64", i), 384'(decdone64), 384'(1'b1));
            end
            if (k == 28) begin
                chk($sformatf("v%0d_done_1cyc", i), 384'(decdone), 384'(1'b0));
                chk($sformatf("v%0d_pt_hold", i), 384'(plaintext), 384'(pv_end));
                chk($sformatf("v%0d_tag_hold", i), 384'(tag_out), 384'(vecs[i].exp_tag));
            end
            if (intrude && (k == 5 || k == 27)) begin
                start      = 1'b1;
                state_in   = vecs[6].st;
                ciphertext = vecs[1].ct ^ 192'h5;
                tag_in     = vecs[1].tag;
            end
        end
    endtask

    // Starts vector i, resets in cycle S+kr, checks S+kr+1, then restarts
    // at S+kr+2.
    task automatic abort_run(input int i, input int kr);
        state_in   = vecs[i].st;
        ciphertext = vecs[i].ct;
        tag_in     = vecs[i].tag;
        start      = 1'b1;
        for (int k = 1; k <= kr; k++) begin
            tick();
            start = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk($sformatf("abort%0d_pt", kr), 384'(plaintext), 384'(0));
        chk($sformatf("abort%0d_tag", kr), 384'(tag_out), 384'(0));
        chk($sformatf("abort%0d_ok", kr), 384'(tag_ok), 384'(0));
        chk($sformatf("abort%0d_busy", kr), 384'(busy), 384'(0));
        chk($sformatf("abort%0d_done", kr), 384'(decdone), 384'(0));
        tick();
        run_vec(i, 1'b0);
    endtask

    initial begin
        bit stray;
        logic [383:0] s1, s2;
        logic [191:0] p1, p2;
        s1 = 384'h000102030405060708090A0B0C0D0E0F_101112131415161718191A1B1C1D1E1F_202122232425262728292A2B2C2D2E2F;
        s2 = {12{32'h9E3779B9}} ^ 384'hC3;
        p1 = 192'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677;
        p2 = 192'hA5A5A5A5_5A5A5A5A_00000000_FFFFFFFF_13579BDF_2468ACE0;
        vecs[0] = '{s1, p1, 192'h0,          128'h0,          1'b1, 1'b1, '0, '0, '0};
        vecs[1] = '{s1, p1, 192'h1,          128'h0,          1'b0, 1'b0, '0, '0, '0};
        vecs[2] = '{s1, p1, 192'h0,          128'h1,          1'b0, 1'b1, '0, '0, '0};
        vecs[3] = '{s1, p1, 192'h0,          128'h1 << 127,   1'b0, 1'b0, '0, '0, '0};
        vecs[4] = '{s1, p1, 192'h1 << 191,   128'h0,          1'b0, 1'b0, '0, '0, '0};
        vecs[5] = '{s1, p1, 192'h0,          128'h1 << 63,    1'b0, 1'b1, '0, '0, '0};
        vecs[6] = '{s2, p2, 192'h0,          128'h0,          1'b1, 1'b1, '0, '0, '0};
        vecs[7] = '{s2, p2, 192'h0,          128'h1 << 64,    1'b0, 1'b0, '0, '0, '0};
        for (int i = 0; i < 8; i++) prep(i);

        reset = 1'b1; start = 1'b0;
        state_in = '0; ciphertext = '0; tag_in = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_pt", 384'(plaintext), 384'(0));
        chk("rst_tag", 384'(tag_out), 384'(0));
        chk("rst_ok", 384'(tag_ok), 384'(0));
        chk("rst_busy", 384'(busy), 384'(0));
        chk("rst_done", 384'(decdone), 384'(0));

        // Table vectors, issued back-to-back.
        for (int i = 0; i < 8; i++) run_vec(i, 1'b0);

        // Starts at S+5 and S+27 must be ignored.
        run_vec(0, 1'b1);
        stray = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (busy || decdone) stray = 1'b1;
        end
        chk("busy_reject_no_second_op", 384'(stray), 384'(0));

        abort_run(0, 10);
        abort_run(6, 20);

        // Reset and start together: reset wins.
        state_in = vecs[0].st; ciphertext = vecs[0].ct; tag_in = vecs[0].tag;
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        stray = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (busy || decdone) stray = 1'b1;
            tick();
        end
        chk("reset_beats_start", 384'(stray), 384'(0));
        run_vec(6, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
